// File: rtl/jk_bank_sched_if.sv
// jk_bank_sched_if: requester-side command handshake for jk_bank_sched
// Ports (signals):
//   req_valid[NREQ]      per-requester command valid (requester -> scheduler)
//   req_ready[NREQ]      per-requester accept, one-hot or zero (scheduler -> requester)
//   req_cmd[2*NREQ]      command slice r = [2r+1:2r]; 00 hold, 01 reset, 10 set, 11 toggle
//   req_idx[IDXW*NREQ]   target flop index, slice r
// Modports: master = requester side, slave = scheduler side.
interface jk_bank_sched_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [2*NREQ-1:0]    req_cmd;
  logic [IDXW*NREQ-1:0] req_idx;
  modport master (output req_valid, req_cmd, req_idx, input req_ready);
  modport slave  (input req_valid, req_cmd, req_idx, output req_ready);
endinterface

// File: rtl/jk_bank_sched.sv
// jk_bank_sched: round-robin scheduler sharing one JK flop bank among NREQ requesters
// Ports:
//   clk        rising-edge clock, shared with the bank
//   rst_n      synchronous active-low reset
//   bus        jk_bank_sched_if.slave: req_valid/req_ready/req_cmd/req_idx
//   j, k       registered J/K drive of the bank, one bit pulsed for one cycle per command
//   q          bank outputs
//   rsp_valid  registered one-cycle response pulse to the owning requester
//   rsp_q      sampled q of the target flop
//   rsp_err    bad index, or (with JK_SCHED_VERIFY_EN) q differs from the expected value
//   busy       high whenever the FSM is not IDLE
// Optional build macro: JK_SCHED_VERIFY_EN enables the post-command q comparison.
module jk_bank_sched #(
  parameter int NREQ = 4,
  parameter int NFF  = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  jk_bank_sched_if.slave  bus,
  output logic [NFF-1:0]  j,
  output logic [NFF-1:0]  k,
  input  logic [NFF-1:0]  q,
  output logic [NREQ-1:0] rsp_valid,
  output logic            rsp_q,
  output logic            rsp_err,
  output logic            busy
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;
  state_t          state;
  logic [PW-1:0]   ptr, win, own;
  logic            found;
  logic [1:0]      w_cmd;
  logic [IDXW-1:0] w_idx, idx;
  logic [NFF-1:0]  w_sel, sel;
  logic            c_q, err;
  int              r;
  // Winner search walks upward from ptr with wrap-around; the decoded
  // flop selects double as index validation (no bit set means idx >= NFF).
  always_comb begin
    found = 1'b0;
    win   = '0;
    w_cmd = '0;
    w_idx = '0;
    r     = 0;
    for (int i = 0; i < NREQ; i++) begin
      r = int'(ptr) + i;
      r = r >= NREQ ? r - NREQ : r;
      if (!found && bus.req_valid[r]) begin
        found = 1'b1;
        win   = PW'(r);
        w_cmd = bus.req_cmd[2*r +: 2];
        w_idx = bus.req_idx[IDXW*r +: IDXW];
      end
    end
    bus.req_ready = '0;
    if (rst_n && state == IDLE && found) bus.req_ready[win] = 1'b1;
    for (int i = 0; i < NFF; i++) begin
      w_sel[i] = w_idx == IDXW'(i);
      sel[i]   = idx == IDXW'(i);
    end
    c_q = |(sel & q);
  end
`ifdef JK_SCHED_VERIFY_EN
  logic [1:0] cmd;
  logic       q_before, exp_q;
  assign exp_q = &cmd ? ~q_before : ^cmd ? cmd[1] : q_before;
  assign err   = ~|sel | (c_q != exp_q);
`else
  assign err = ~|sel;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      own       <= '0;
      idx       <= '0;
      j         <= '0;
      k         <= '0;
      rsp_valid <= '0;
      rsp_q     <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
`ifdef JK_SCHED_VERIFY_EN
      cmd       <= '0;
      q_before  <= 1'b0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: if (found) begin
          own   <= win;
          idx   <= w_idx;
          j     <= w_sel & {NFF{w_cmd[1]}};
          k     <= w_sel & {NFF{w_cmd[0]}};
          busy  <= 1'b1;
          state <= ISSUE;
`ifdef JK_SCHED_VERIFY_EN
          cmd      <= w_cmd;
          q_before <= |(w_sel & q);
`endif
        end
        ISSUE: begin
          j     <= '0;
          k     <= '0;
          state <= CHECK;
        end
        default: begin
          rsp_q          <= c_q;
          rsp_err        <= err;
          rsp_valid[own] <= 1'b1;
          ptr            <= own == PW'(NREQ - 1) ? '0 : own + 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jk_bank_sched.sv
// tb_jk_bank_sched: randomized + directed bench for jk_bank_sched against a transaction-level model
module tb_jk_bank_sched;
  localparam int NREQ = 4;
  localparam int NFF  = 8;
  localparam int IDXW = 4;
`ifdef JK_SCHED_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  typedef struct {logic [1:0] cmd; logic [IDXW-1:0] idx;} req_t;
  typedef struct {int due; int owner; logic q; logic err;} rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bank_clr = 1'b1;
  logic [NFF-1:0] j, k, q, stuck;
  logic [NREQ-1:0] rsp_valid;
  logic rsp_q, rsp_err, busy;
  always #5 clk = ~clk;

  jk_bank_sched_if #(.NREQ(NREQ), .IDXW(IDXW)) bus ();
  jk_bank_sched #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .j(j), .k(k), .q(q),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy));

  // behavioural JK bank with optional stuck-at-0 bits
  always @(posedge clk)
    for (int i = 0; i < NFF; i++)
      q[i] <= (bank_clr || stuck[i]) ? 1'b0 : (j[i] && k[i]) ? ~q[i] : j[i] ? 1'b1 : k[i] ? 1'b0 : q[i];

  int compared = 0, mismatched = 0;
  int cyc = 0, free_at = 0, last_grant = -100, ptr_m = 0;
  logic [15:0] mq = '0;
  logic [NFF-1:0] pj = '0, pk = '0;
  rsp_t pend[$];
  req_t rq[NREQ][$];

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, o, e, cyc);
    end
  endtask

  function automatic bit anyq();
    for (int r = 0; r < NREQ; r++) if (rq[r].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(int r, logic [1:0] c, int ix);
    req_t t;
    t.cmd = c;
    t.idx = IDXW'(ix);
    rq[r].push_back(t);
  endtask

  task automatic model_grant(int w);
    req_t c = rq[w][0];
    logic [15:0] st = 16'(stuck);
    logic bad = int'(c.idx) >= NFF;
    logic qb = bad ? 1'b0 : mq[c.idx];
    logic ideal = c.cmd == 2'd0 ? qb : c.cmd == 2'd1 ? 1'b0 : c.cmd == 2'd2 ? 1'b1 : ~qb;
    logic act = (bad || st[c.idx]) ? 1'b0 : ideal;
    rsp_t e;
    if (!bad) mq[c.idx] = act;
    pj = (bad || !c.cmd[1]) ? '0 : NFF'(1) << c.idx;
    pk = (bad || !c.cmd[0]) ? '0 : NFF'(1) << c.idx;
    e.due = cyc + 3;
    e.owner = w;
    e.q = act;
    e.err = bad | (VER & (act != ideal));
    pend.push_back(e);
    last_grant = cyc;
    free_at = cyc + 3;
    ptr_m = (w + 1) % NREQ;
  endtask

  task automatic step(logic rs = 1'b1);
    logic [NREQ-1:0] er = '0, ev = '0;
    int w = -1;
    rsp_t e;
    @(negedge clk);
    rst_n = rs;
    bank_clr = cyc < 2;
    for (int r = 0; r < NREQ; r++) begin
      bus.req_valid[r] = rq[r].size() > 0;
      bus.req_cmd[2*r +: 2] = rq[r].size() > 0 ? rq[r][0].cmd : 2'd0;
      bus.req_idx[IDXW*r +: IDXW] = rq[r].size() > 0 ? rq[r][0].idx : '0;
    end
    #1;
    if (rst_n && cyc >= free_at)
      for (int i = 0; i < NREQ; i++) begin
        int r2 = (ptr_m + i) % NREQ;
        if (w < 0 && bus.req_valid[r2]) w = r2;
      end
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    if (cyc > 0) begin
      chk("j", 32'(j), cyc == last_grant + 1 ? 32'(pj) : 32'd0);
      chk("k", 32'(k), cyc == last_grant + 1 ? 32'(pk) : 32'd0);
      chk("busy", 32'(busy), 32'(cyc - last_grant == 1 || cyc - last_grant == 2));
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e = pend.pop_front();
        ev[e.owner] = 1'b1;
        chk("rsp_q", 32'(rsp_q), 32'(e.q));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    end
    if (w >= 0) model_grant(w);
    for (int r = 0; r < NREQ; r++)
      if (bus.req_ready[r] && bus.req_valid[r]) void'(rq[r].pop_front());
    @(posedge clk);
    cyc++;
    if (!rs) begin
      pend.delete();
      last_grant = -100;
      free_at = 0;
      ptr_m = 0;
    end
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while ((anyq() || pend.size() > 0) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(anyq() || pend.size() > 0), 32'd0);
  endtask

  initial begin
    stuck = '0;
    bus.req_valid = '0;
    bus.req_cmd = '0;
    bus.req_idx = '0;
    // reset then idle
    step(1'b0);
    step(1'b0);
    step();
    step();
    chk("rst_rsp_q", 32'(rsp_q), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    // single set, req 0, idx 3
    push(0, 2'b10, 3);
    drain(20);
    // toggle chain, req 1, idx 5
    repeat (4) push(1, 2'b11, 5);
    drain(40);
    // arbitration from ptr=0 with all valids, then {1,3} after serving 1
    step(1'b0);
    push(0, 2'b01, 0); push(0, 2'b10, 1); push(1, 2'b10, 4); push(2, 2'b11, 6); push(3, 2'b00, 7);
    drain(40);
    push(1, 2'b11, 1); push(1, 2'b11, 1); push(3, 2'b10, 6);
    drain(40);
    // bad index
    push(2, 2'b10, 9);
    push(0, 2'b11, 15);
    drain(20);
    // stuck-at-0 flop: mismatch is reported only in the verifying build
    stuck = NFF'(1) << 2;
    push(2, 2'b10, 2);
    push(3, 2'b11, 2);
    drain(20);
    stuck = '0;
    // reset during ISSUE, pointer returns to 0 and the request is re-granted
    push(1, 2'b00, 0);
    drain(20);
    push(3, 2'b10, 7);
    step();
    step(1'b0);
    push(3, 2'b10, 7);
    push(1, 2'b01, 4);
    drain(40);
    // randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int r = $urandom_range(0, NREQ - 1);
        if (rq[r].size() < 3) push(r, 2'($urandom_range(0, 3)), $urandom_range(0, 9));
      end
      step($urandom_range(0, 60) != 0);
    end
    drain(300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
